phys_reg_free_list: RTL and testbench
=====================================

Name: phys_reg_free_list

Overview:
- Circular-buffer free list of physical registers for the 64-entry, 3-read-port physical regfile.
- Hands up to 3 free physical tags per cycle to rename; takes back up to 3 released tags per cycle from commit.
- Keeps a speculative head and an architectural (committed) head, so a pipeline flush can roll back speculative allocations in one cycle.
- Physical register 0 is hard-wired ground: never allocated, never enqueued.

Parameters:
- NUM_PREGS, 64, number of physical registers. Tag width is 7 bits.
- NUM_AREGS, 32, architectural registers. Pregs 0..31 are identity-mapped at reset.
- WIDTH, 3, alloc and free lanes per cycle.
- DEPTH, NUM_PREGS-NUM_AREGS = 32, free-list capacity. Pointers are log2(DEPTH)+1 = 6 bits, including a wrap bit.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- alloc_req  in  WIDTH  per-lane request from rename, lane 0 = oldest
- alloc_grant  out  1  all requested lanes served this cycle
- alloc_preg  out  WIDTH x 7  allocated tag per lane; valid only where alloc_req & alloc_grant
- free_valid  in  WIDTH  per-lane release from commit
- free_preg  in  WIDTH x 7  released tags (old mapping of the committed rd)
- commit_alloc_cnt  in  2  allocations retired this cycle (0..3); advances the architectural head
- flush  in  1  mispredict/exception recovery
- free_count  out  6  entries currently free (0..32)
- empty  out  1  free_count == 0

Behaviour:
- **Storage:** fifo[DEPTH] of 7-bit tags; spec_head, arch_head and tail are 6-bit pointers. The index is ptr[4:0].
- **Occupancy:** free_count = tail - spec_head, modulo 64.
- **Reset:**
  - fifo[i] = 32+i for i = 0..31.
  - spec_head = arch_head = 0; tail = 32 (wrap bit set, index 0).
  - free_count = 32, empty = 0, alloc_grant = 0.
- **Allocation (combinational, all-or-nothing):**
  - n = popcount(alloc_req).
  - alloc_grant = (n != 0) & (free_count >= n) & ~flush.
  - Requesting lanes, compacted in lane order, receive fifo[spec_head], fifo[spec_head+1], and so on. Example: req=3'b101 gives lane0 fifo[h] and lane2 fifo[h+1].
  - Non-requesting lanes output 7'd0.
- **Spec head update:** on posedge, if alloc_grant then spec_head += n. Partial grants never occur.
- **Availability:** the grant decision uses the registered free_count only. Tags freed this cycle become allocatable next cycle; there is no bypass.
- **Free (enqueue):**
  - Each lane with free_valid=1 and free_preg != 0 is written, compacted in lane order, at fifo[tail], fifo[tail+1], and so on.
  - tail += number written.
  - A lane with free_preg == 0 is silently dropped.
- **Commit:** on posedge, arch_head += commit_alloc_cnt.
- **Flush:**
  - On posedge, spec_head <= arch_head + commit_alloc_cnt, i.e. the same-cycle commit is honoured.
  - alloc_grant is forced to 0 during flush.
  - Frees in the flush cycle are still enqueued.
- **Simultaneous alloc + free + commit:** all three pointers update independently in the same edge. Next free_count = old + written - (grant ? n : 0).
- **Wrap-around:** pointers wrap modulo 64. The wrap bit distinguishes full (32) from empty (0).
- **Reset precedence:** reset overrides flush, alloc and free in the same cycle. Reset mid-operation returns to the reset state.
- **Assertions:**
  - Free enqueue never exceeds capacity: free_count + written <= 32.
  - arch_head never passes spec_head: spec_head - arch_head <= 32.
  - No alloc_preg lane is ever 0 when granted.
  - commit_alloc_cnt <= 3.

Decomposition:
- typedefs package adds:
  - constants NUM_PREGS, NUM_AREGS, FL_DEPTH;
  - type preg_t (7 bits);
  - structs flAllocReqStruct, flAllocRespStruct, flFreeStruct, for later port bundling alongside regReqStruct/regRespStruct.
- One natural sub-module: lane_compactor. Given a WIDTH-bit mask, it produces per-lane offsets and a popcount, and is used by both the alloc and free paths.

Test Plan:
- Reset, then alloc_req=3'b111 -> grant=1, alloc_preg = {32,33,34}; next cycle free_count = 29.
- Eleven cycles of 3'b111 requests -> the first 10 are granted (30 tags); the 11th sees free_count=2, so grant=0 and spec_head is unchanged; a single 3'b001 request then gets 62.
- With free_count=1: free_valid=3'b011 tags {5,7} plus alloc_req=3'b011 in the same cycle -> grant=0 (no bypass). Next cycle free_count=3 and the retried alloc gets {63,5}.
- Alloc 6 tags over 2 cycles, then commit_alloc_cnt=2 with flush=1 -> spec_head = arch_head = 2, free_count = 30, grant=0 in the flush cycle. The next alloc of 1 returns tag 34.
- free_valid=3'b111 with tags {0,40,41} -> only 40 and 41 are enqueued; tail advances by 2.
- Drain and refill 3+ times across the pointer wrap -> the FIFO order of tags is preserved, free_count is correct at the 0 and 32 boundaries, and no assertion fires.

Source files
------------

// File: rtl/phys_reg_free_list_pkg.sv
// Shared sizing, tag type and port-bundle structs for the physical register free list.
package phys_reg_free_list_pkg;

  localparam int NUM_PREGS = 64;
  localparam int NUM_AREGS = 32;
  localparam int FL_DEPTH  = NUM_PREGS - NUM_AREGS;
  localparam int FL_WIDTH  = 3;
  localparam int PREG_W    = 7;
  localparam int IDX_W     = $clog2(FL_DEPTH);
  localparam int PTR_W     = IDX_W + 1;
  localparam int CNT_W     = $clog2(FL_WIDTH + 1);

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [PTR_W-1:0]  fl_ptr_t;
  typedef logic [FL_WIDTH-1:0][CNT_W-1:0] lane_off_t;

  typedef struct packed {
    logic [FL_WIDTH-1:0] req;
  } flAllocReqStruct;

  typedef struct packed {
    logic                grant;
    preg_t [FL_WIDTH-1:0] preg;
  } flAllocRespStruct;

  typedef struct packed {
    logic [FL_WIDTH-1:0]  valid;
    preg_t [FL_WIDTH-1:0] preg;
  } flFreeStruct;

endpackage

// File: rtl/phys_reg_free_list_lane_compactor.sv
// Turns a lane mask into per-lane slot offsets (prefix count of lower active lanes) and a total.
module phys_reg_free_list_lane_compactor
  import phys_reg_free_list_pkg::*;
(
  input  logic [FL_WIDTH-1:0] mask,
  output lane_off_t           offset,
  output logic [CNT_W-1:0]    count
);

  logic [CNT_W-1:0] running;

  always_comb begin
    running = '0;
    offset  = '0;
    for (int i = 0; i < FL_WIDTH; i++) begin
      offset[i] = running;
      running   = running + CNT_W'(mask[i]);
    end
    count = running;
  end

endmodule

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags with a speculative and a committed head,
// so a flush can return every uncommitted allocation in a single cycle.
module phys_reg_free_list
  import phys_reg_free_list_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [FL_WIDTH-1:0]  alloc_req,
  output logic                 alloc_grant,
  output preg_t [FL_WIDTH-1:0] alloc_preg,
  input  logic [FL_WIDTH-1:0]  free_valid,
  input  preg_t [FL_WIDTH-1:0] free_preg,
  input  logic [1:0]           commit_alloc_cnt,
  input  logic                 flush,
  output logic [PTR_W-1:0]     free_count,
  output logic                 empty
);

  preg_t               fifo_q [FL_DEPTH];
  preg_t               fifo_d [FL_DEPTH];
  fl_ptr_t             spec_head_q, spec_head_d;
  fl_ptr_t             arch_head_q, arch_head_d;
  fl_ptr_t             tail_q, tail_d;
  fl_ptr_t             rd_ptr [FL_WIDTH];
  fl_ptr_t             wr_ptr [FL_WIDTH];
  logic [FL_WIDTH-1:0] free_keep;
  lane_off_t           alloc_off, free_off;
  logic [CNT_W-1:0]    alloc_n, free_n;
  logic                granted_zero;

  phys_reg_free_list_lane_compactor u_alloc_compact (
    .mask   (alloc_req),
    .offset (alloc_off),
    .count  (alloc_n)
  );

  phys_reg_free_list_lane_compactor u_free_compact (
    .mask   (free_keep),
    .offset (free_off),
    .count  (free_n)
  );

  assign free_count = tail_q - spec_head_q;
  assign empty      = (free_count == '0);

  // Grant only from registered occupancy; tags freed this cycle are not visible yet.
  always_comb begin
    alloc_grant  = (alloc_n != '0) && (free_count >= fl_ptr_t'(alloc_n)) && !flush;
    granted_zero = 1'b0;
    for (int i = 0; i < FL_WIDTH; i++) begin
      rd_ptr[i]     = spec_head_q + fl_ptr_t'(alloc_off[i]);
      alloc_preg[i] = alloc_req[i] ? fifo_q[rd_ptr[i][IDX_W-1:0]] : '0;
      if (alloc_grant && alloc_req[i] && (alloc_preg[i] == '0)) granted_zero = 1'b1;
    end
  end

  always_comb begin
    fifo_d = fifo_q;
    for (int i = 0; i < FL_WIDTH; i++) begin
      free_keep[i] = free_valid[i] && (free_preg[i] != '0);
    end
    for (int i = 0; i < FL_WIDTH; i++) begin
      wr_ptr[i] = tail_q + fl_ptr_t'(free_off[i]);
      if (free_keep[i]) fifo_d[wr_ptr[i][IDX_W-1:0]] = free_preg[i];
    end
    tail_d      = tail_q + fl_ptr_t'(free_n);
    arch_head_d = arch_head_q + fl_ptr_t'(commit_alloc_cnt);
    // Flush rewinds to the committed head including this cycle's retirements.
    if (flush)            spec_head_d = arch_head_d;
    else if (alloc_grant) spec_head_d = spec_head_q + fl_ptr_t'(alloc_n);
    else                  spec_head_d = spec_head_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FL_DEPTH; i++) fifo_q[i] <= preg_t'(NUM_AREGS + i);
      spec_head_q <= '0;
      arch_head_q <= '0;
      tail_q      <= fl_ptr_t'(FL_DEPTH);
    end else begin
      fifo_q      <= fifo_d;
      spec_head_q <= spec_head_d;
      arch_head_q <= arch_head_d;
      tail_q      <= tail_d;
    end
  end

  a_free_capacity: assert property (@(posedge clk) disable iff (reset)
    (7'(free_count) + 7'(free_n)) <= 7'(FL_DEPTH));

  a_arch_behind_spec: assert property (@(posedge clk) disable iff (reset)
    fl_ptr_t'(spec_head_q - arch_head_q) <= fl_ptr_t'(FL_DEPTH));

  a_grant_nonzero: assert property (@(posedge clk) disable iff (reset) !granted_zero);

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Randomized and directed bench for phys_reg_free_list against a queue-based free-list model.
module tb_phys_reg_free_list;
  import phys_reg_free_list_pkg::*;

  logic           clk = 1'b0;
  logic           reset;
  logic [2:0]     alloc_req;
  logic           alloc_grant;
  preg_t [2:0]    alloc_preg;
  logic [2:0]     free_valid;
  preg_t [2:0]    free_preg;
  logic [1:0]     commit_alloc_cnt;
  logic           flush;
  logic [5:0]     free_count;
  logic           empty;

  int checks = 0;
  int errors = 0;

  // Model: fl holds tags from the committed head to the tail in order;
  // the first spec_off of them are speculatively handed out. out_pool holds tags in use.
  int fl[$];
  int out_pool[$];
  int spec_off;

  preg_t [2:0] seen_preg;
  logic        seen_grant;

  always #5 clk = ~clk;

  phys_reg_free_list dut (
    .clk              (clk),
    .reset            (reset),
    .alloc_req        (alloc_req),
    .alloc_grant      (alloc_grant),
    .alloc_preg       (alloc_preg),
    .free_valid       (free_valid),
    .free_preg        (free_preg),
    .commit_alloc_cnt (commit_alloc_cnt),
    .flush            (flush),
    .free_count       (free_count),
    .empty            (empty)
  );

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  task automatic modelReset();
    fl.delete();
    out_pool.delete();
    for (int i = 0; i < 32; i++) fl.push_back(32 + i);
    for (int i = 1; i < 32; i++) out_pool.push_back(i);
    spec_off = 0;
  endtask

  task automatic removeFromPool(input int tag);
    for (int i = 0; i < out_pool.size(); i++) begin
      if (out_pool[i] == tag) begin
        out_pool.delete(i);
        break;
      end
    end
  endtask

  // Reset is asserted together with every other input active to show it wins.
  task automatic doReset();
    reset            = 1'b1;
    alloc_req        = 3'b111;
    free_valid       = 3'b111;
    free_preg        = {7'd9, 7'd8, 7'd7};
    commit_alloc_cnt = 2'd3;
    flush            = 1'b1;
    @(posedge clk);
    #1;
    reset            = 1'b0;
    alloc_req        = '0;
    free_valid       = '0;
    free_preg        = '0;
    commit_alloc_cnt = '0;
    flush            = 1'b0;
    modelReset();
    #1;
    checkOutput("reset_free_count", int'(free_count), 32);
    checkOutput("reset_empty", int'(empty), 0);
    checkOutput("reset_grant", int'(alloc_grant), 0);
  endtask

  task automatic applyStimulus(input logic [2:0] req, input logic [2:0] fv,
                               input preg_t [2:0] fp, input int commit, input logic fl_flush);
    int n, avail, k;
    bit exp_grant;
    alloc_req        = req;
    free_valid       = fv;
    free_preg        = fp;
    commit_alloc_cnt = 2'(commit);
    flush            = fl_flush;
    #1;
    n         = $countones(req);
    avail     = fl.size() - spec_off;
    exp_grant = (n != 0) && (avail >= n) && !fl_flush;
    seen_preg  = alloc_preg;
    seen_grant = alloc_grant;
    checkOutput("free_count", int'(free_count), avail);
    checkOutput("empty", int'(empty), int'(avail == 0));
    checkOutput("alloc_grant", int'(alloc_grant), int'(exp_grant));
    k = 0;
    for (int i = 0; i < 3; i++) begin
      if (req[i]) begin
        if (exp_grant) checkOutput("alloc_preg", int'(alloc_preg[i]), fl[spec_off + k]);
        k++;
      end else begin
        checkOutput("alloc_preg_idle", int'(alloc_preg[i]), 0);
      end
    end
    @(posedge clk);
    if (exp_grant) spec_off += n;
    for (int c = 0; c < commit; c++) begin
      out_pool.push_back(fl.pop_front());
      spec_off--;
    end
    if (fl_flush) spec_off = 0;
    for (int i = 0; i < 3; i++) begin
      if (fv[i] && fp[i] != 0) fl.push_back(int'(fp[i]));
    end
    #1;
  endtask

  task automatic randomCycle(input bit alloc_heavy);
    logic [2:0]  req, fv;
    preg_t [2:0] fp;
    int          commit, maxc, room, idx;
    logic        fl_flush;
    if (alloc_heavy || $urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
    else req = 3'b000;
    maxc     = (spec_off < 3) ? spec_off : 3;
    commit   = $urandom_range(0, maxc);
    fl_flush = ($urandom_range(0, 19) == 0);
    room     = 32 - fl.size();
    fv       = '0;
    fp       = '0;
    for (int i = 0; i < 3; i++) begin
      if ($urandom_range(0, 3) < (alloc_heavy ? 1 : 3)) begin
        if ($urandom_range(0, 7) == 0) begin
          fv[i] = 1'b1;
        end else if (room > 0 && out_pool.size() > 0) begin
          idx   = $urandom_range(0, out_pool.size() - 1);
          fv[i] = 1'b1;
          fp[i] = preg_t'(out_pool[idx]);
          out_pool.delete(idx);
          room--;
        end
      end
    end
    applyStimulus(req, fv, fp, commit, fl_flush);
  endtask

  initial begin
    doReset();

    // First triple, then exhaust the list three at a time.
    applyStimulus(3'b111, '0, '0, 0, 1'b0);
    checkOutput("first_lane0", int'(seen_preg[0]), 32);
    checkOutput("first_lane1", int'(seen_preg[1]), 33);
    checkOutput("first_lane2", int'(seen_preg[2]), 34);
    checkOutput("first_free_count", int'(free_count), 29);
    for (int c = 0; c < 10; c++) begin
      applyStimulus(3'b111, '0, '0, 0, 1'b0);
      if (c == 9) checkOutput("eleventh_grant", int'(seen_grant), 0);
    end
    checkOutput("after_eleven_free_count", int'(free_count), 2);
    applyStimulus(3'b001, '0, '0, 0, 1'b0);
    checkOutput("single_tag", int'(seen_preg[0]), 62);

    // Frees are not allocatable in the same cycle.
    applyStimulus(3'b000, '0, '0, 3, 1'b0);
    removeFromPool(5);
    removeFromPool(7);
    applyStimulus(3'b011, 3'b011, {7'd0, 7'd7, 7'd5}, 0, 1'b0);
    checkOutput("no_bypass_grant", int'(seen_grant), 0);
    checkOutput("no_bypass_count", int'(free_count), 3);
    applyStimulus(3'b011, '0, '0, 0, 1'b0);
    checkOutput("retry_lane0", int'(seen_preg[0]), 63);
    checkOutput("retry_lane1", int'(seen_preg[1]), 5);

    // Flush honours the same-cycle commit.
    doReset();
    applyStimulus(3'b111, '0, '0, 0, 1'b0);
    applyStimulus(3'b111, '0, '0, 0, 1'b0);
    applyStimulus(3'b001, '0, '0, 2, 1'b1);
    checkOutput("flush_grant", int'(seen_grant), 0);
    checkOutput("flush_free_count", int'(free_count), 30);
    applyStimulus(3'b001, '0, '0, 0, 1'b0);
    checkOutput("post_flush_tag", int'(seen_preg[0]), 34);

    // Retire tags up to 43, then release 40/41 alongside a ground tag.
    for (int c = 0; c < 3; c++) applyStimulus(3'b111, '0, '0, 0, 1'b0);
    applyStimulus(3'b000, '0, '0, 3, 1'b0);
    applyStimulus(3'b000, '0, '0, 3, 1'b0);
    applyStimulus(3'b000, '0, '0, 3, 1'b0);
    applyStimulus(3'b000, '0, '0, 1, 1'b0);
    removeFromPool(40);
    removeFromPool(41);
    applyStimulus(3'b000, 3'b111, {7'd41, 7'd40, 7'd0}, 0, 1'b0);
    checkOutput("drop_zero_count", int'(free_count), 22);

    // Alternate drain and refill phases to wrap the pointers repeatedly.
    for (int p = 0; p < 10; p++) begin
      if (p == 5) doReset();
      for (int c = 0; c < 60; c++) randomCycle(p[0] == 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
